// File: rtl/game_pkg.sv
// Shared types and constants for the match scorer: FSM state encoding and
// the active-low 7-segment table (digits 0-9, index 10 is blank).
package game_pkg;

  typedef enum logic [1:0] {
    StPlay = 2'd0,
    StHold = 2'd1,
    StOver = 2'd2
  } state_e;

  localparam logic [3:0] DigitBlank = 4'd10;
  localparam logic [6:0] SegBlank   = 7'b1111111;

  // Packed table, index 10 is the most significant entry.
  localparam logic [10:0][6:0] SegTable = {
    SegBlank,   // 10
    7'b0010000, // 9
    7'b0000000, // 8
    7'b1111000, // 7
    7'b0000010, // 6
    7'b0010010, // 5
    7'b0011001, // 4
    7'b0110000, // 3
    7'b0100100, // 2
    7'b1111001, // 1
    7'b1000000  // 0
  };

endpackage

// File: rtl/seg7_digit.sv
// Active-low 7-segment decoder; 10 and any out-of-range value show blank.
module seg7_digit
  import game_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SegBlank;
    if (value <= DigitBlank) begin
      seg = SegTable[value];
    end
  end

endmodule

// File: rtl/match_scorer.sv
// Two-player round/match scorer: counts round wins, holds the playfield for a
// fixed number of cycles between rounds and freezes once a player wins.
module match_scorer
  import game_pkg::*;
#(
  parameter int unsigned WINS_NEEDED = 3,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       LED9,
  input  logic       LED1,
  input  logic       L,
  input  logic       R,
  output logic [6:0] hex_p1,
  output logic [6:0] hex_p2,
  output logic [6:0] winner,
  output logic       round_reset,
  output logic       match_over
);

  localparam int unsigned ScoreW = $clog2(WINS_NEEDED + 1);
  localparam int unsigned HoldW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [ScoreW-1:0] WinsVal  = ScoreW'(WINS_NEEDED);
  localparam logic [HoldW-1:0]  HoldLoad = HoldW'(HOLD_CYCLES - 1);

  state_e              state_q, state_d;
  logic [ScoreW-1:0]   score1_q, score1_d;
  logic [ScoreW-1:0]   score2_q, score2_d;
  logic [HoldW-1:0]    hold_q, hold_d;

  logic p1_evt, p2_evt;
  logic [3:0] win_digit;

  // Simultaneous presses cancel, so both-LEDs-lit is resolved by L/R alone.
  assign p1_evt = LED9 & L & ~R;
  assign p2_evt = LED1 & R & ~L;

  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    hold_d   = hold_q;
    case (state_q)
      StPlay: begin
        if (p1_evt) begin
          score1_d = score1_q + 1'b1;
          state_d  = (score1_d == WinsVal) ? StOver : StHold;
          hold_d   = HoldLoad;
        end else if (p2_evt) begin
          score2_d = score2_q + 1'b1;
          state_d  = (score2_d == WinsVal) ? StOver : StHold;
          hold_d   = HoldLoad;
        end
      end
      StHold: begin
        if (hold_q == '0) begin
          state_d = StPlay;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      StOver: ;
      default: state_d = StPlay;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StPlay;
      score1_q <= '0;
      score2_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      hold_q   <= hold_d;
    end
  end

  assign round_reset = (state_q == StHold);
  assign match_over  = (state_q == StOver);

  always_comb begin
    win_digit = DigitBlank;
    if (state_q == StOver) begin
      win_digit = (score1_q == WinsVal) ? 4'd1 : 4'd2;
    end
  end

  seg7_digit u_seg_p1 (
    .value (4'(score1_q)),
    .seg   (hex_p1)
  );

  seg7_digit u_seg_p2 (
    .value (4'(score2_q)),
    .seg   (hex_p2)
  );

  seg7_digit u_seg_win (
    .value (win_digit),
    .seg   (winner)
  );

endmodule

// File: tb/tb_match_scorer.sv
// Scoreboard bench for match_scorer: a behavioural model queues the expected
// outputs for each driven cycle and they are compared after the clock edge.
module tb_match_scorer;

  localparam int unsigned Wins = 3;
  localparam int unsigned Hold = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       LED9 = 1'b0;
  logic       LED1 = 1'b0;
  logic       L = 1'b0;
  logic       R = 1'b0;
  logic [6:0] hex_p1, hex_p2, winner;
  logic       round_reset, match_over;

  match_scorer #(
    .WINS_NEEDED (Wins),
    .HOLD_CYCLES (Hold)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .LED9        (LED9),
    .LED1        (LED1),
    .L           (L),
    .R           (R),
    .hex_p1      (hex_p1),
    .hex_p2      (hex_p2),
    .winner      (winner),
    .round_reset (round_reset),
    .match_over  (match_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] h1;
    logic [6:0] h2;
    logic [6:0] win;
    logic       rr;
    logic       mo;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail = 0;

  // Model state: 0 play, 1 hold, 2 over; m_left counts remaining hold cycles.
  int m_st = 0;
  int m_s1 = 0;
  int m_s2 = 0;
  int m_left = 0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic l9, input logic l1, input logic l,
                      input logic r);
    exp_t e;
    reset = rst_n;
    LED9  = l9;
    LED1  = l1;
    L     = l;
    R     = r;
    if (!rst_n) begin
      m_st = 0; m_s1 = 0; m_s2 = 0; m_left = 0;
    end else begin
      case (m_st)
        0: begin
          if (l9 && l && !r) begin
            m_s1++;
            if (m_s1 == Wins) m_st = 2;
            else begin m_st = 1; m_left = Hold; end
          end else if (l1 && r && !l) begin
            m_s2++;
            if (m_s2 == Wins) m_st = 2;
            else begin m_st = 1; m_left = Hold; end
          end
        end
        1: begin
          if (m_left == 1) m_st = 0;
          else m_left--;
        end
        default: ;
      endcase
    end
    e.h1  = seg_of(m_s1);
    e.h2  = seg_of(m_s2);
    e.win = (m_st == 2) ? ((m_s1 == Wins) ? seg_of(1) : seg_of(2)) : 7'b1111111;
    e.rr  = (m_st == 1);
    e.mo  = (m_st == 2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("hex_p1", 32'(hex_p1), 32'(e.h1));
      check_eq("hex_p2", 32'(hex_p2), 32'(e.h2));
      check_eq("winner", 32'(winner), 32'(e.win));
      check_eq("round_reset", 32'(round_reset), 32'(e.rr));
      check_eq("match_over", 32'(match_over), 32'(e.mo));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic p1_round();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(Hold);
  endtask

  task automatic p2_round();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(Hold);
  endtask

  initial begin
    #1;
    do_reset();

    // Single P1 win with the press held through the whole hold period.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < Hold; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Both LEDs and both buttons: no event.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    // Both LEDs, single button decides.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(Hold + 1);

    // P2 takes the match, then activity is ignored.
    do_reset();
    p2_round();
    p2_round();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset during the second hold cycle.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Reset has priority over a simultaneous win event.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Alternate to 2-2, then P1 wins.
    do_reset();
    p1_round();
    p2_round();
    p1_round();
    p2_round();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/match_scorer.md
MATCH_SCORER -- requirements
Module: match_scorer

Interface
REQ-001 SHALL have parameter: WINS_NEEDED, 3, round wins that end the match (legal range 1..9).
REQ-002 SHALL have parameter: HOLD_CYCLES, 4, cycles spent in the round-end hold before play resumes (minimum 1).
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-low reset; it is sampled on the clk rising edge and asserts when 0.
REQ-005 SHALL have port: LED9  input  1  leftmost playfield light lit (player 1 end).
REQ-006 SHALL have port: LED1  input  1  rightmost playfield light lit (player 2 end).
REQ-007 SHALL have port: L  input  1  player 1 press (level).
REQ-008 SHALL have port: R  input  1  player 2 press (level).
REQ-009 SHALL have port: hex_p1  output  7  active-low 7-seg digit of player 1 score.
REQ-010 SHALL have port: hex_p2  output  7  active-low 7-seg digit of player 2 score.
REQ-011 SHALL have port: winner  output  7  active-low 7-seg: "1" or "2" once the match is decided, blank otherwise.
REQ-012 SHALL have port: round_reset  output  1  high while the playfield must re-centre.
REQ-013 SHALL have port: match_over  output  1  high once a player has reached WINS_NEEDED.

Function
REQ-014 SHALL implement FSM states PLAY, HOLD, OVER.
REQ-015 SHALL define a P1 round-win event in PLAY as LED9 & L & ~R, sampled at the clk edge.
REQ-016 SHALL define a P2 round-win event in PLAY as LED1 & R & ~L, sampled at the clk edge.
REQ-017 SHALL treat L and R both high as no event, regardless of LEDs.
REQ-018 SHALL, when LED9 and LED1 are both high, decide the event by L/R alone; L only gives P1, R only gives P2.
REQ-019 SHALL, on an event edge, increment the scorer's count by 1 at that same edge.
REQ-020 SHALL, on an event edge, go to OVER if the new count equals WINS_NEEDED, otherwise go to HOLD with the hold counter loaded to HOLD_CYCLES-1.
REQ-021 SHALL, in HOLD, decrement the hold counter each cycle, ignore L/R/LED inputs, and return to PLAY on the edge where the counter reads 0.
REQ-022 SHALL make HOLD last exactly HOLD_CYCLES cycles.
REQ-023 SHALL make OVER absorbing: scores, winner and match_over stay frozen and all inputs are ignored until reset.
REQ-024 SHALL derive outputs from registered state only (Moore), so each output changes one edge after the causing event.
REQ-025 SHALL drive round_reset = 1 exactly in HOLD and 0 in PLAY and OVER.
REQ-026 SHALL drive match_over = 1 exactly in OVER.
REQ-027 SHALL drive winner as "1" (1111001) or "2" (0100100) per the player that reached WINS_NEEDED, and 1111111 otherwise.
REQ-028 SHALL hold score counters at $clog2(WINS_NEEDED+1) bits, never exceeding WINS_NEEDED.
REQ-029 SHALL encode digits active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Reset
REQ-030 SHALL, on reset=0 at any clk edge in any state (including mid-HOLD), go to PLAY with both scores 0 and the hold counter 0.
REQ-031 SHALL, after reset, output hex_p1 = hex_p2 = 1000000, winner = 1111111, round_reset = 0, match_over = 0.
REQ-032 SHALL give reset priority over any simultaneous win event.

Structure
REQ-033 SHALL place the state enum and the 7-seg constant table (digits 0-9, blank) in a shared package, game_pkg.
REQ-034 SHALL use one sub-module, seg7_digit (4-bit value -> active-low 7-seg), instantiated three times, with value 10 giving blank.

Verification
REQ-035 SHALL check, with WINS_NEEDED=3 and HOLD_CYCLES=4: after reset, LED9=1, L=1, R=0 for one edge -> hex_p1=1111001 and round_reset=1 for exactly 4 cycles, then PLAY.
REQ-036 SHALL check: LED9=LED1=1, L=R=1 for 5 edges -> scores stay 0 and round_reset stays 0.
REQ-037 SHALL check: an event is held through HOLD -> only one increment per round.
REQ-038 SHALL check: P2 wins 3 rounds -> hex_p2=0110000, winner=0100100, match_over=1, then further L/R/LED activity changes nothing.
REQ-039 SHALL check: reset=0 asserted during the 2nd HOLD cycle -> next edge gives PLAY, scores 0, round_reset=0.
REQ-040 SHALL check: P1 and P2 alternate to a 2-2 score, then P1 wins -> winner=1111001, hex_p1=0110000, hex_p2=0100100.
